// File: rtl/mem_access_unit_pkg.sv
// Shared types and width helpers for the memory access unit.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } stateT;

  // Bits needed for a wait counter that must be able to hold maxWait.
  function automatic int cntWidth(input int maxWait);
    return (maxWait < 1) ? 1 : $clog2(maxWait + 1);
  endfunction

  // Bits needed for a channel index; one bit minimum for a single channel.
  function automatic int ptrWidth(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  localparam int MAXWAIT_LIMIT = 255;
  localparam int WAIT_W_MAX    = cntWidth(MAXWAIT_LIMIT);

endpackage

// File: rtl/mem_access_unit_if.sv
// Requester and memory-side bus bundle for the memory access unit.
interface mem_access_unit_if #(
  parameter int WIDTH = 16,
  parameter int NCH   = 2
);
  logic [NCH-1:0]       reqValid;
  logic [NCH-1:0]       reqWrite;
  logic [NCH*WIDTH-1:0] reqAdr;
  logic [NCH*WIDTH-1:0] reqData;
  logic [NCH-1:0]       reqReady;
  logic [NCH-1:0]       respValid;
  logic [WIDTH-1:0]     respData;
  logic                 respErr;
  logic                 memRead;
  logic                 memWrite;
  logic [WIDTH-1:0]     adrToMem;
  logic [WIDTH-1:0]     dataToMem;
  logic                 memAck;
  logic [WIDTH-1:0]     dataFromMem;

  // Unit side: takes requests and memory completions, drives grants, responses, strobes.
  modport slave (
    input  reqValid, reqWrite, reqAdr, reqData, memAck, dataFromMem,
    output reqReady, respValid, respData, respErr, memRead, memWrite, adrToMem, dataToMem
  );

  // Environment side: requesters plus the memory model.
  modport master (
    output reqValid, reqWrite, reqAdr, reqData, memAck, dataFromMem,
    input  reqReady, respValid, respData, respErr, memRead, memWrite, adrToMem, dataToMem
  );
endinterface

// File: rtl/mem_access_unit_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or above ptr, wrapping.
module rr_arbiter
  import mem_access_unit_pkg::*;
#(
  parameter int NCH = 2,
  parameter int PW  = ptrWidth(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [NCH-1:0] grant
);

  logic found;
  int   idx;

  // Scan upward from ptr and take the first pending channel.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = (int'(ptr) + i) % NCH;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-channel memory access unit: arbitrates requesters onto one memory port,
// waits for memAck with a timeout, and returns a one-cycle response to the owner.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NCH     = 2,
  parameter int MAXWAIT = 15
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_unit_if.slave   bus,
  output logic               busy
);

  localparam int PW = ptrWidth(NCH);
  localparam int CW = cntWidth(MAXWAIT);

  stateT            state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    owner;
  logic [CW-1:0]    waitCnt;
  logic [NCH-1:0]   grant;
  logic [NCH-1:0]   ownerHot;
  logic [PW-1:0]    winIdx;
  logic [WIDTH-1:0] winAdr;
  logic [WIDTH-1:0] winData;
  logic             winWrite;

  rr_arbiter #(.NCH(NCH), .PW(PW)) uArb (
    .req   (bus.reqValid),
    .ptr   (ptr),
    .grant (grant)
  );

  // Grants are only offered while idle; the reset term keeps reqReady low during reset.
  assign bus.reqReady = (state == IDLE && reset) ? grant : '0;
  assign busy         = (state != IDLE);

  // Encode the winning channel and pick out its request fields.
  always_comb begin
    winIdx   = '0;
    winAdr   = '0;
    winData  = '0;
    winWrite = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) begin
        winIdx   = PW'(i);
        winAdr   = bus.reqAdr[i*WIDTH +: WIDTH];
        winData  = bus.reqData[i*WIDTH +: WIDTH];
        winWrite = bus.reqWrite[i];
      end
    end
  end

  // One-hot of the channel that owns the in-flight access.
  always_comb begin
    ownerHot        = '0;
    ownerHot[owner] = 1'b1;
  end

  // Main sequencer; every bus output is registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      ptr           <= '0;
      owner         <= '0;
      waitCnt       <= '0;
      bus.respValid <= '0;
      bus.respData  <= '0;
      bus.respErr   <= 1'b0;
      bus.memRead   <= 1'b0;
      bus.memWrite  <= 1'b0;
      bus.adrToMem  <= '0;
      bus.dataToMem <= '0;
    end else begin
      bus.respValid <= '0;
      case (state)
        IDLE: begin
          if (|grant) begin
            state         <= ACCESS;
            owner         <= winIdx;
            ptr           <= (winIdx == PW'(NCH - 1)) ? '0 : winIdx + PW'(1);
            bus.adrToMem  <= winAdr;
            bus.dataToMem <= winData;
            bus.memWrite  <= winWrite;
            bus.memRead   <= !winWrite;
            waitCnt       <= '0;
          end
        end
        ACCESS: begin
          // memAck is checked first so a completion on the last wait cycle is not an error.
          if (bus.memAck) begin
            bus.memRead   <= 1'b0;
            bus.memWrite  <= 1'b0;
            bus.respData  <= bus.memWrite ? '0 : bus.dataFromMem;
            bus.respErr   <= 1'b0;
            bus.respValid <= ownerHot;
            waitCnt       <= '0;
            state         <= RESP;
          end else if (waitCnt == CW'(MAXWAIT)) begin
            bus.memRead   <= 1'b0;
            bus.memWrite  <= 1'b0;
            bus.respData  <= '0;
            bus.respErr   <= 1'b1;
            bus.respValid <= ownerHot;
            waitCnt       <= '0;
            state         <= RESP;
          end else begin
            waitCnt <= waitCnt + CW'(1);
          end
        end
        RESP: begin
          bus.respData <= '0;
          bus.respErr  <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
